// File: rtl/noc_config_pkg.sv
// Shared NoC configuration: parameter range limits and the locking-arbiter state encoding.
package noc_config_pkg;

    localparam int PORTS_MIN       = 2;
    localparam int PORTS_MAX       = 8;
    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 8;
    localparam int GRANT_DEPTH_MIN = 1;
    localparam int GRANT_DEPTH_MAX = 8;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_fifo.sv
// Small circular FIFO with occupancy count; pops on an empty FIFO and pushes on a full one are dropped.
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_r, wr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_s, push_s;

    assign empty  = (count_r == CNT_W'(0));
    assign pop_s  = pop & ~empty;
    assign push_s = push & ((count_r != CNT_W'(DEPTH)) | pop_s);
    assign head   = mem_r[rd_r];
    assign count  = count_r;

    // Storage, read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_r    <= '0;
            wr_r    <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_r] <= push_data;
                wr_r        <= (wr_r == AW'(DEPTH - 1)) ? AW'(0) : wr_r + AW'(1);
            end
            if (pop_s) begin
                rd_r <= (rd_r == AW'(DEPTH - 1)) ? AW'(0) : rd_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/noc_locking_rr_arbiter.sv
// Round-robin arbiter that locks onto its winner until 'free'; pointer moves past the winner on release.
module noc_locking_rr_arbiter
    import noc_config_pkg::*;
#(
    parameter int REQUESTS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REQUESTS-1:0] request,
    input  logic                free,
    output logic [REQUESTS-1:0] grant,
    output logic                locked
);
    localparam int PTR_W = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

    arb_state_e          state_r, state_nxt_s;
    logic [PTR_W-1:0]    ptr_r, ptr_nxt_s, winner_r, winner_nxt_s, pick_idx_s;
    logic [REQUESTS-1:0] req_hi_s, sel_s, pick_oh_s;

    assign locked = (state_r == ARB_LOCKED);

    // Requests at or above the pointer take priority; otherwise wrap to the lowest index.
    always_comb begin
        req_hi_s   = request & ~((REQUESTS'(1'b1) << ptr_r) - REQUESTS'(1'b1));
        sel_s      = (|req_hi_s) ? req_hi_s : request;
        pick_oh_s  = sel_s & (~sel_s + REQUESTS'(1'b1));
        pick_idx_s = '0;
        for (int j = 0; j < REQUESTS; j++) begin
            pick_idx_s = pick_idx_s | (PTR_W'(j) & {PTR_W{pick_oh_s[j]}});
        end
    end

    // Grant: live pick while idle, stored winner while locked.
    always_comb begin
        grant = '0;
        case (state_r)
            ARB_IDLE:   grant = pick_oh_s;
            ARB_LOCKED: grant = REQUESTS'(1'b1) << winner_r;
            default:    grant = '0;
        endcase
    end

    // Next state: lock on any request, release on free.
    always_comb begin
        state_nxt_s  = state_r;
        winner_nxt_s = winner_r;
        ptr_nxt_s    = ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (|request) begin
                    state_nxt_s  = ARB_LOCKED;
                    winner_nxt_s = pick_idx_s;
                end else begin
                    state_nxt_s  = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (free) begin
                    state_nxt_s = ARB_IDLE;
                    ptr_nxt_s   = (winner_r == PTR_W'(REQUESTS - 1)) ? PTR_W'(0) : winner_r + PTR_W'(1);
                end else begin
                    state_nxt_s = ARB_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State, winner and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ARB_IDLE;
            winner_r <= '0;
            ptr_r    <= '0;
        end else begin
            state_r  <= state_nxt_s;
            winner_r <= winner_nxt_s;
            ptr_r    <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/noc_vc_port_scheduler.sv
// Output-port scheduler: per-VC packet-locked port arbitration, VC arbitration and an ordered grant FIFO.
// Optional NOC_VC_PORT_SCHEDULER_PRIORITY_EN adds i_priority to restrict which ports compete.
module noc_vc_port_scheduler
    import noc_config_pkg::*;
#(
    parameter int PORTS       = 5,
    parameter int CHANNELS    = 2,
    parameter int GRANT_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CHANNELS-1:0][PORTS-1:0]      i_sop,
    input  logic [CHANNELS-1:0][PORTS-1:0]      i_eop,
    input  logic [CHANNELS-1:0][PORTS-1:0]      i_request,
    input  logic [CHANNELS-1:0][PORTS-1:0]      i_free,
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
    input  logic [CHANNELS-1:0][PORTS-1:0]      i_priority,
`endif
    output logic [CHANNELS-1:0][PORTS-1:0]      o_grant,
    input  logic [CHANNELS-1:0]                 i_vc_available,
    output logic [PORTS-1:0]                    o_output_grant,
    input  logic                                i_output_free,
    output logic [$clog2(GRANT_DEPTH+1)-1:0]    o_grant_count
);
    localparam int CNT_W  = $clog2(GRANT_DEPTH + 1);
    localparam int CNT1_W = CNT_W + 1;

    if (PORTS < PORTS_MIN || PORTS > PORTS_MAX) begin : g_bad_ports
        $error("noc_vc_port_scheduler: PORTS out of range");
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("noc_vc_port_scheduler: CHANNELS out of range");
    end
    if (GRANT_DEPTH < GRANT_DEPTH_MIN || GRANT_DEPTH > GRANT_DEPTH_MAX) begin : g_bad_depth
        $error("noc_vc_port_scheduler: GRANT_DEPTH out of range");
    end

    logic [PORTS-1:0]    port_grant_s [CHANNELS];
    logic [CHANNELS-1:0] port_locked_s, port_free_s, vc_request_s, vc_grant_s;
    logic                vc_locked_s, vc_ok_s, vc_free_any_s, vc_free_s, fifo_empty_s;
    logic [PORTS-1:0]    push_data_s, fifo_head_s;
    logic [CNT_W-1:0]    fifo_count_s;

    // Reserve a FIFO slot for the packet currently holding the VC lock.
    assign vc_ok_s = ({1'b0, fifo_count_s} + CNT1_W'(vc_locked_s)) < CNT1_W'(GRANT_DEPTH);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [PORTS-1:0] port_req_s;
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
        assign port_req_s = (|(i_sop[c] & i_priority[c])) ? (i_sop[c] & i_priority[c]) : i_sop[c];
`else
        assign port_req_s = i_sop[c];
`endif
        assign port_free_s[c]  = port_locked_s[c] & (|(i_eop[c] & port_grant_s[c]));
        assign vc_request_s[c] = (|(i_request[c] & port_grant_s[c])) & i_vc_available[c] & vc_ok_s;

        noc_locking_rr_arbiter #(.REQUESTS(PORTS)) u_port_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .request (port_req_s),
            .free    (port_free_s[c]),
            .grant   (port_grant_s[c]),
            .locked  (port_locked_s[c])
        );
    end

    noc_locking_rr_arbiter #(.REQUESTS(CHANNELS)) u_vc_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (vc_request_s),
        .free    (vc_free_s),
        .grant   (vc_grant_s),
        .locked  (vc_locked_s)
    );

    // Release condition and pushed port for the VC-granted channel.
    always_comb begin
        vc_free_any_s = 1'b0;
        push_data_s   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            vc_free_any_s = vc_free_any_s | (vc_grant_s[c] & (|(i_free[c] & port_grant_s[c])));
            push_data_s   = push_data_s | (port_grant_s[c] & {PORTS{vc_grant_s[c]}});
        end
    end

    assign vc_free_s = vc_locked_s & vc_free_any_s;

    noc_fifo #(.WIDTH(PORTS), .DEPTH(GRANT_DEPTH)) u_grant_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vc_free_s),
        .push_data (push_data_s),
        .pop       (i_output_free),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    // Flit grants are forced low during reset since idle arbiters grant combinationally.
    always_comb begin
        o_grant = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            o_grant[c] = (vc_grant_s[c] & rst_n) ? port_grant_s[c] : '0;
        end
    end

    assign o_output_grant = (fifo_empty_s | ~rst_n) ? '0 : fifo_head_s;
    assign o_grant_count  = fifo_count_s;

endmodule

// File: tb/tb_noc_vc_port_scheduler.sv
// Scoreboard bench: a queue/array reference model predicts each cycle's outputs; a monitor compares on negedge.
module tb_noc_vc_port_scheduler;
    localparam int P  = 5;
    localparam int CH = 2;
    localparam int D  = 2;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CH-1:0][P-1:0] i_sop, i_eop, i_request, i_free, o_grant;
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
    logic [CH-1:0][P-1:0] i_priority;
`endif
    logic [CH-1:0] i_vc_available;
    logic [P-1:0]  o_output_grant;
    logic          i_output_free;
    logic [CW-1:0] o_grant_count;

    typedef struct {
        int                   cyc;
        logic [CH-1:0][P-1:0] grant;
        logic [P-1:0]         out_grant;
        logic [CW-1:0]        count;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    int port_owner[CH];
    int port_ptr[CH];
    int vc_owner;
    int vc_ptr;
    int fifo_q[$];

    always #5 clk = ~clk;

    noc_vc_port_scheduler #(.PORTS(P), .CHANNELS(CH), .GRANT_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_sop          (i_sop),
        .i_eop          (i_eop),
        .i_request      (i_request),
        .i_free         (i_free),
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
        .i_priority     (i_priority),
`endif
        .o_grant        (o_grant),
        .i_vc_available (i_vc_available),
        .o_output_grant (o_output_grant),
        .i_output_free  (i_output_free),
        .o_grant_count  (o_grant_count)
    );

    function automatic int rr_pick(input logic [7:0] req, input int n, input int ptr);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [P-1:0] rbits(input int pct);
        logic [P-1:0] v;
        for (int i = 0; i < P; i++) v[i] = ($urandom_range(99) < pct);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            port_owner[c] = -1;
            port_ptr[c] = 0;
        end
        vc_owner = -1;
        vc_ptr = 0;
        fifo_q.delete();
    endtask

    // Predict this cycle's outputs from current inputs, then advance the model past the next edge.
    task automatic model_step();
        exp_t e;
        int pg[CH];
        logic [7:0] req;
        logic [7:0] vreq;
        int vg;
        int pdata;
        bit push;
        e.cyc = cyc;
        e.grant = '0;
        e.out_grant = '0;
        e.count = '0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        for (int c = 0; c < CH; c++) begin
            req = '0;
            req[P-1:0] = i_sop[c];
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
            if ((i_sop[c] & i_priority[c]) != '0) req[P-1:0] = i_sop[c] & i_priority[c];
`endif
            pg[c] = (port_owner[c] >= 0) ? port_owner[c] : rr_pick(req, P, port_ptr[c]);
        end
        vreq = '0;
        for (int c = 0; c < CH; c++) begin
            vreq[c] = (pg[c] >= 0) && i_request[c][pg[c]] && i_vc_available[c] &&
                      (fifo_q.size() + ((vc_owner >= 0) ? 1 : 0) < D);
        end
        vg = (vc_owner >= 0) ? vc_owner : rr_pick(vreq, CH, vc_ptr);
        for (int c = 0; c < CH; c++) begin
            if (c == vg && pg[c] >= 0) e.grant[c][pg[c]] = 1'b1;
        end
        if (fifo_q.size() > 0) e.out_grant[fifo_q[0]] = 1'b1;
        e.count = CW'(fifo_q.size());
        exp_q.push_back(e);

        for (int c = 0; c < CH; c++) begin
            if (port_owner[c] < 0) begin
                port_owner[c] = pg[c];
            end else if (i_eop[c][port_owner[c]]) begin
                port_ptr[c] = (port_owner[c] + 1) % P;
                port_owner[c] = -1;
            end
        end
        push = 1'b0;
        pdata = 0;
        if (vc_owner < 0) begin
            vc_owner = vg;
        end else if (pg[vc_owner] >= 0 && i_free[vc_owner][pg[vc_owner]]) begin
            push = 1'b1;
            pdata = pg[vc_owner];
            vc_ptr = (vc_owner + 1) % CH;
            vc_owner = -1;
        end
        if (i_output_free && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (push) fifo_q.push_back(pdata);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [CH*P-1:0] sop, input logic [CH*P-1:0] eop,
                         input logic [CH*P-1:0] req, input logic [CH*P-1:0] fr,
                         input logic [CH-1:0] av, input logic ofree, input logic rn);
        i_sop = sop;
        i_eop = eop;
        i_request = req;
        i_free = fr;
        i_vc_available = av;
        i_output_free = ofree;
        rst_n = rn;
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
        i_priority = '0;
`endif
        step();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want, input int c);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
        end
    endtask

    // Monitor: compare every presented output cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_grant", 32'(o_grant), 32'(e.grant), e.cyc);
                chk("o_output_grant", 32'(o_output_grant), 32'(e.out_grant), e.cyc);
                chk("o_grant_count", 32'(o_grant_count), 32'(e.count), e.cyc);
            end
        end
    end

    localparam logic [CH*P-1:0] Z = '0;
    localparam logic [CH*P-1:0] R = 10'b00001_11111;

    initial begin
        model_reset();
        drive('1, Z, '1, Z, 2'b11, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive('1, Z, '1, Z, 2'b11, 1'b1, 1'b0);
        drive('1, Z, '1, Z, 2'b11, 1'b1, 1'b0);
        // Port lock, eop masking, rr pointer, VC blocking, FIFO full/pop, push+pop, mid-packet reset.
        drive(10'b00000_10100, Z, 10'b00000_11111, Z, 2'b11, 1'b0, 1'b1);
        drive(10'b00000_10100, 10'b00000_10000, 10'b00000_11111, Z, 2'b11, 1'b0, 1'b1);
        drive(10'b00000_10100, 10'b00000_00100, 10'b00000_11111, Z, 2'b11, 1'b0, 1'b1);
        drive(10'b00001_10100, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(10'b00001_10100, Z, R, 10'b00000_10000, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, R, 10'b00001_00000, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, R, Z, 2'b11, 1'b1, 1'b1);
        drive(Z, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, R, 10'b00000_10000, 2'b11, 1'b1, 1'b1);
        drive(Z, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(10'b00000_00011, Z, R, Z, 2'b11, 1'b0, 1'b0);
        drive(10'b00000_00011, Z, R, Z, 2'b11, 1'b0, 1'b0);
        drive(10'b00000_00011, Z, R, Z, 2'b11, 1'b0, 1'b1);
        drive(Z, Z, Z, Z, 2'b11, 1'b0, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                i_sop[c] = rbits(30);
                i_eop[c] = rbits(20);
                i_request[c] = rbits(70);
                i_free[c] = rbits(25);
                i_vc_available[c] = ($urandom_range(9) < 8);
`ifdef NOC_VC_PORT_SCHEDULER_PRIORITY_EN
                i_priority[c] = rbits(30);
`endif
            end
            i_output_free = ($urandom_range(99) < 30);
            rst_n = ($urandom_range(299) != 0);
            step();
        end

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_vc_port_scheduler.md
NOC_VC_PORT_SCHEDULER -- requirements
Module: noc_vc_port_scheduler

Interface
REQ-001 SHALL have parameter PORTS, default 5, number of input ports competing for this output (range 2..8).
REQ-002 SHALL have parameter CHANNELS, default 2, number of virtual channels (range 1..8).
REQ-003 SHALL have parameter GRANT_DEPTH, default 2, grant FIFO entries (range 1..8).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_sop  input  CHANNELS x PORTS  start-of-packet request per channel/port.
REQ-007 i_eop  input  CHANNELS x PORTS  end-of-packet per channel/port; releases port lock.
REQ-008 i_request  input  CHANNELS x PORTS  flit request per channel/port.
REQ-009 i_free  input  CHANNELS x PORTS  last flit accepted per channel/port; releases VC lock.
REQ-010 o_grant  output  CHANNELS x PORTS  flit grant per channel/port.
REQ-011 i_vc_available  input  CHANNELS  downstream VC has space.
REQ-012 o_output_grant  output  PORTS  one-hot port select for the output mux.
REQ-013 i_output_free  input  1  output stage finished current packet; pops grant FIFO.
REQ-014 o_grant_count  output  clog2(GRANT_DEPTH+1)  grant FIFO occupancy.

Function
REQ-015 Per channel, a port arbiter SHALL have states IDLE and LOCKED.
REQ-016 IDLE: if any i_sop[c] bit set, SHALL select winner round-robin starting at pointer, drive port_grant[c] one-hot combinationally same cycle, go LOCKED.
REQ-017 LOCKED: port_grant[c] SHALL hold the winner regardless of i_sop; on i_eop[c][winner] SHALL return to IDLE next cycle, pointer := (winner+1) mod PORTS.
REQ-018 i_eop bits of non-winning ports SHALL be ignored.
REQ-019 vc_request[c] SHALL equal OR(i_request[c] & port_grant[c]) & i_vc_available[c] & vc_ok.
REQ-020 vc_ok SHALL be 1 only when o_grant_count + (VC lock active ? 1 : 0) < GRANT_DEPTH, so the FIFO never overflows.
REQ-021 VC arbiter SHALL be round-robin over CHANNELS with IDLE/LOCKED states identical to REQ-016/017, released by OR(i_free[c] & port_grant[c]) of the locked channel.
REQ-022 o_grant[c] SHALL equal port_grant[c] when VC c is granted, else zero; at most one channel nonzero per cycle.
REQ-023 On the VC release cycle, port_grant of the released channel SHALL be pushed into the grant FIFO.
REQ-024 i_output_free with FIFO non-empty SHALL pop; with FIFO empty SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL keep occupancy unchanged and preserve order.
REQ-026 o_output_grant SHALL equal FIFO head when non-empty, else zero; zero latency from head change.
REQ-027 Pointers SHALL wrap PORTS-1 -> 0 and CHANNELS-1 -> 0.

Reset
REQ-028 On rst_n low, all arbiters SHALL go IDLE, pointers to 0, FIFO empty; o_grant, o_output_grant, o_grant_count SHALL be 0 while reset asserted.
REQ-029 Reset mid-packet SHALL discard locks and FIFO content with no residual grant after release.

Configuration
REQ-030 With NOC_VC_PORT_SCHEDULER_PRIORITY_EN defined, an input i_priority (CHANNELS x PORTS) SHALL exist; in IDLE, if any i_sop & i_priority bit set, only those ports SHALL compete round-robin.
REQ-031 Without the macro, i_priority SHALL not exist and all i_sop ports compete equally.

Structure
REQ-032 Parameter range limits and the IDLE/LOCKED enum SHALL live in noc_config_pkg.
REQ-033 Port and VC arbitration SHALL reuse one sub-module, noc_locking_rr_arbiter (REQUESTS parameter, request/grant/free ports); the grant FIFO SHALL use the existing noc_fifo.

Verification
REQ-034 PORTS=5,CHANNELS=2: i_sop[0]=5'b10100 at reset exit -> port_grant[0]=5'b00100 same cycle; after eop on port 2, next sop 5'b10100 -> 5'b10000.
REQ-035 VC0 locked, i_request[1] active with port granted -> o_grant[1]=0 until VC0 i_free, then VC1 granted the following cycle.
REQ-036 GRANT_DEPTH=2, three packets completed, no i_output_free -> count 2, third VC request blocked, o_grant all zero until one pop.
REQ-037 Push and i_output_free same cycle with count 1 -> count stays 1, o_output_grant shows new packet's port next cycle.
REQ-038 rst_n asserted while VC1 locked and FIFO count 1 -> all outputs 0 immediately, after release port 0 arbitration starts from pointer 0.
REQ-039 Macro defined: i_sop[0]=5'b00011, i_priority[0]=5'b00010 -> port_grant[0]=5'b00010.
